// File: rtl/gf32_mul_arbiter.sv
// rtl/gf32_mul_arbiter.sv - round-robin arbiter sharing one external GF(2^32) multiplier
module gf32_mul_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_REQ-1:0]    i_req_start,
    input  logic [32*N_REQ-1:0] i_req_x,
    input  logic [32*N_REQ-1:0] i_req_y,
    output logic [N_REQ-1:0]    o_req_done,
    output logic [31:0]         o_req_out,
    output logic                o_start_mul32,
    output logic [31:0]         o_x_mul32,
    output logic [31:0]         o_y_mul32,
    input  logic [31:0]         i_o_mul32,
    input  logic                i_done_mul32,
    output logic                o_busy,
    output logic [IDX_W-1:0]    o_grant_idx,
    output logic                o_err
);

    // One extra bit so rr_ptr + offset never overflows before the modulo wrap.
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [N_REQ-1:0]   pending_q,   pending_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [31:0]        req_out_q,   req_out_d;
    logic [N_REQ-1:0]   req_done_q,  req_done_d;
    logic               err_q,       err_d;

    logic [IDX_W-1:0]   rr_winner;
    logic               rr_found;
    logic [CNT_W-1:0]   rr_sum;
    logic [IDX_W-1:0]   rr_cand;
    logic [N_REQ-1:0]   clr_mask;
    logic [N_REQ-1:0]   dup_start;

    // Round-robin search: first pending index at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        rr_winner = '0;
        rr_found  = 1'b0;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + CNT_W'(k);
            if (rr_sum >= CNT_W'(N_REQ)) begin
                rr_sum = rr_sum - CNT_W'(N_REQ);
            end
            rr_cand = rr_sum[IDX_W-1:0];
            if (!rr_found && pending_q[rr_cand]) begin
                rr_winner = rr_cand;
                rr_found  = 1'b1;
            end
        end
    end

    // Operand mux: the multiplier always sees the slices of the granted requester.
    always_comb begin
        o_x_mul32 = '0;
        o_y_mul32 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx_q == IDX_W'(k)) begin
                o_x_mul32 = i_req_x[32*k +: 32];
                o_y_mul32 = i_req_y[32*k +: 32];
            end
        end
    end

    // Next-state, pending bookkeeping and error detection.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        req_out_d   = req_out_q;
        req_done_d  = '0;
        err_d       = err_q;
        clr_mask    = '0;
        dup_start   = '0;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    grant_idx_d = rr_winner;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_done_mul32) begin
                    req_out_d             = i_o_mul32;
                    clr_mask[grant_idx_q] = 1'b1;
                    req_done_d            = clr_mask;
                    rr_ptr_d              = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0
                                                                               : grant_idx_q + 1'b1;
                    state_d               = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A multiplier completion we are not waiting for is a protocol violation.
        if (i_done_mul32 && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end

        // A bit being cleared on this edge is free again, so a start on it is not a duplicate.
        dup_start = i_req_start & pending_q & ~clr_mask;
        if (|dup_start) begin
            err_d = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | i_req_start;
    end

    // State register with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            req_out_q   <= '0;
            req_done_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            req_out_q   <= req_out_d;
            req_done_q  <= req_done_d;
            err_q       <= err_d;
        end
    end

    assign o_start_mul32 = (state_q == S_ISSUE);
    assign o_busy        = (state_q != S_IDLE);
    assign o_grant_idx   = grant_idx_q;
    assign o_req_out     = req_out_q;
    assign o_req_done    = req_done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_gf32_mul_arbiter.sv
// tb/tb_gf32_mul_arbiter.sv - scoreboard bench for gf32_mul_arbiter with a 4-cycle GF(2^32) multiplier model
module tb_gf32_mul_arbiter;

    localparam int N  = 3;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    i_req_start;
    logic [32*N-1:0] i_req_x;
    logic [32*N-1:0] i_req_y;
    logic [N-1:0]    o_req_done;
    logic [31:0]     o_req_out;
    logic            o_start_mul32;
    logic [31:0]     o_x_mul32;
    logic [31:0]     o_y_mul32;
    logic [31:0]     i_o_mul32;
    logic            i_done_mul32;
    logic            o_busy;
    logic [IW-1:0]   o_grant_idx;
    logic            o_err;

    gf32_mul_arbiter #(.N_REQ(N)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_start   (i_req_start),
        .i_req_x       (i_req_x),
        .i_req_y       (i_req_y),
        .o_req_done    (o_req_done),
        .o_req_out     (o_req_out),
        .o_start_mul32 (o_start_mul32),
        .o_x_mul32     (o_x_mul32),
        .o_y_mul32     (o_y_mul32),
        .i_o_mul32     (i_o_mul32),
        .i_done_mul32  (i_done_mul32),
        .o_busy        (o_busy),
        .o_grant_idx   (o_grant_idx),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] prod;
        int          cyc;
        bit          granted;
    } sb_t;

    sb_t  sb[$];
    int   grant_log[$];
    int   checks = 0;
    int   failures = 0;
    int   ptr = 0;
    int   cur_grant = 0;
    bit   model_wait = 1'b0;
    bit   expect_done = 1'b0;
    logic [31:0] last_out = '0;
    int   last_ostart_cyc = 0;
    int   done_cnt [N];
    int   spur_req = 0;
    int   spur_ack = 0;
    int   mul_cnt = 0;
    logic [31:0] mul_prod = '0;

    // GF(2^32) product modulo x^32 + x^7 + x^3 + x^2 + 1, shift-and-add.
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] acc;
        logic [31:0] t;
        acc = '0;
        t   = a;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) acc = acc ^ t;
            t = t[31] ? ((t << 1) ^ 32'h0000_008D) : (t << 1);
        end
        return acc;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_req_start = '0;
    endtask

    function automatic bit has_entry(input int idx);
        foreach (sb[i]) if (sb[i].idx == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic issue(input int idx, input logic [31:0] x, input logic [31:0] y);
        sb_t e;
        i_req_x[32*idx +: 32] = x;
        i_req_y[32*idx +: 32] = y;
        i_req_start[idx]      = 1'b1;
        e.idx = idx; e.x = x; e.y = y; e.prod = gf_mul(x, y); e.cyc = cyc; e.granted = 1'b0;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || o_busy) && n < 500) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < 500), 32'd1);
    endtask

    function automatic logic [31:0] rnd_op();
        int s;
        s = $urandom_range(0, 3);
        if (s == 0) return 32'h0000_0000;
        if (s == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    // Multiplier model: done exactly 4 cycles after a start; can also inject spurious dones.
    initial begin
        i_done_mul32 = 1'b0;
        i_o_mul32    = '0;
        forever begin
            @(negedge clk);
            if (o_start_mul32) begin
                mul_cnt  = 4;
                mul_prod = gf_mul(o_x_mul32, o_y_mul32);
            end
            @(posedge clk);
            #1;
            i_done_mul32 = 1'b0;
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) begin
                    i_done_mul32 = 1'b1;
                    i_o_mul32    = mul_prod;
                end
            end else if (spur_req != spur_ack) begin
                i_done_mul32 = 1'b1;
                i_o_mul32    = $urandom;
                spur_ack++;
            end
        end
    end

    // Monitor: predicts grants from the round-robin rule and checks completions against the scoreboard.
    initial begin
        int best;
        int bestd;
        int d;
        int found;
        foreach (done_cnt[i]) done_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                ptr = 0; cur_grant = 0; model_wait = 1'b0; expect_done = 1'b0; last_out = '0;
                continue;
            end
            if (expect_done) begin
                chk("done_vec", 32'(o_req_done), 32'd1 << cur_grant);
                found = -1;
                foreach (sb[i]) if (found < 0 && sb[i].idx == cur_grant && sb[i].granted) found = i;
                checks++;
                if (found < 0) begin
                    failures++;
                    $display("FAIL done_entry actual=no_entry required=entry_for_req_%0d", cur_grant);
                end else begin
                    chk("req_out", o_req_out, sb[found].prod);
                    last_out = sb[found].prod;
                    sb.delete(found);
                end
                ptr = (cur_grant + 1) % N;
                done_cnt[cur_grant]++;
            end else begin
                chk("no_done", 32'(o_req_done), 32'd0);
                chk("out_hold", o_req_out, last_out);
            end
            if (o_start_mul32) begin
                chk("single_outstanding", 32'(model_wait), 32'd0);
                best  = -1;
                bestd = N;
                foreach (sb[i]) begin
                    if (!sb[i].granted && sb[i].cyc <= cyc - 2) begin
                        d = (sb[i].idx - ptr + N) % N;
                        if (d < bestd) begin bestd = d; best = i; end
                    end
                end
                checks++;
                if (best < 0) begin
                    failures++;
                    $display("FAIL start_eligible actual=start required=no_start (cycle %0d)", cyc);
                end else begin
                    chk("grant_idx", 32'(o_grant_idx), 32'(sb[best].idx));
                    chk("x_mul32", o_x_mul32, sb[best].x);
                    chk("y_mul32", o_y_mul32, sb[best].y);
                    sb[best].granted = 1'b1;
                    cur_grant = sb[best].idx;
                    grant_log.push_back(cur_grant);
                end
                model_wait      = 1'b1;
                last_ostart_cyc = cyc;
            end
            if (i_done_mul32 && model_wait) begin
                expect_done = 1'b1;
                model_wait  = 1'b0;
            end else begin
                expect_done = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        int s1_cyc;
        int b;
        int restarts;
        int n;
        int dc;
        rst = 1'b1; i_req_start = '0; i_req_x = '0; i_req_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_start", 32'(o_start_mul32), 32'd0);
        chk("rst_done",  32'(o_req_done), 32'd0);
        chk("rst_out",   o_req_out, 32'd0);
        chk("rst_grant", 32'(o_grant_idx), 32'd0);
        chk("rst_err",   32'(o_err), 32'd0);
        rst = 1'b0;

        // Single request, start in cycle 10.
        while (cyc < 10) tick();
        s1_cyc = cyc;
        issue(1, 32'h0000_0001, 32'hDEAD_BEEF);
        tick();
        drain("s1_drain");
        chk("s1_start_latency", 32'(last_ostart_cyc), 32'(s1_cyc + 2));
        chk("s1_out", o_req_out, 32'hDEAD_BEEF);
        chk("s1_done_count", 32'(done_cnt[1]), 32'd1);

        // Simultaneous requests from a fresh round-robin pointer.
        do_reset();
        b = grant_log.size();
        issue(0, rnd_op(), rnd_op());
        issue(1, rnd_op(), rnd_op());
        issue(2, rnd_op(), rnd_op());
        tick();
        drain("s2_drain");
        chk("s2_grants", 32'(grant_log.size() - b), 32'd3);
        if (grant_log.size() == b + 3) begin
            chk("s2_g0", 32'(grant_log[b]),     32'd0);
            chk("s2_g1", 32'(grant_log[b + 1]), 32'd1);
            chk("s2_g2", 32'(grant_log[b + 2]), 32'd2);
        end

        // Fairness: 0 and 2 restart as soon as each completes.
        do_reset();
        b = grant_log.size();
        issue(0, rnd_op(), rnd_op());
        issue(2, rnd_op(), rnd_op());
        tick();
        restarts = 0;
        n = 0;
        while ((restarts < 2 || sb.size() != 0 || o_busy) && n < 500) begin
            if (restarts < 2 && o_req_done[0]) begin issue(0, rnd_op(), rnd_op()); restarts++; end
            else if (restarts < 2 && o_req_done[2]) begin issue(2, rnd_op(), rnd_op()); restarts++; end
            tick();
            n++;
        end
        chk("s3_drain", 32'(n < 500), 32'd1);
        chk("s3_grants", 32'(grant_log.size() - b), 32'd4);
        if (grant_log.size() == b + 4) begin
            chk("s3_g0", 32'(grant_log[b]),     32'd0);
            chk("s3_g1", 32'(grant_log[b + 1]), 32'd2);
            chk("s3_g2", 32'(grant_log[b + 2]), 32'd0);
            chk("s3_g3", 32'(grant_log[b + 3]), 32'd2);
        end

        // Wrap-around: serve req 1 so rr_ptr becomes 2, then 0 and 1 together.
        do_reset();
        issue(1, rnd_op(), rnd_op());
        tick();
        drain("s4_pre_drain");
        b = grant_log.size();
        issue(0, rnd_op(), rnd_op());
        issue(1, rnd_op(), rnd_op());
        tick();
        drain("s4_drain");
        if (grant_log.size() == b + 2) begin
            chk("s4_g0", 32'(grant_log[b]),     32'd0);
            chk("s4_g1", 32'(grant_log[b + 1]), 32'd1);
        end else begin
            chk("s4_grants", 32'(grant_log.size() - b), 32'd2);
        end

        // Duplicate start on a pending requester.
        do_reset();
        dc = done_cnt[1];
        issue(1, rnd_op(), rnd_op());
        tick();
        i_req_start[1] = 1'b1;
        tick();
        tick();
        chk("dup_err", 32'(o_err), 32'd1);
        drain("dup_drain");
        repeat (8) tick();
        chk("dup_one_done", 32'(done_cnt[1] - dc), 32'd1);

        // Spurious multiplier done while idle.
        do_reset();
        chk("spur_err_before", 32'(o_err), 32'd0);
        spur_req++;
        tick();
        tick();
        chk("spur_err", 32'(o_err), 32'd1);
        chk("spur_busy", 32'(o_busy), 32'd0);
        chk("spur_grant", 32'(o_grant_idx), 32'd0);
        tick();
        chk("spur_still_idle", 32'(o_busy), 32'd0);

        // Reset during S_WAIT, multiplier completion arrives afterwards.
        do_reset();
        issue(2, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        n = 0;
        while (!(o_busy && !o_start_mul32 && grant_log.size() > 0 && last_ostart_cyc < cyc) && n < 50) begin
            tick();
            n++;
        end
        chk("s6_reach_wait", 32'(n < 50), 32'd1);
        rst = 1'b1;
        #1;
        chk("s6_async_busy",  32'(o_busy), 32'd0);
        chk("s6_async_start", 32'(o_start_mul32), 32'd0);
        chk("s6_async_done",  32'(o_req_done), 32'd0);
        chk("s6_async_out",   o_req_out, 32'd0);
        chk("s6_async_grant", 32'(o_grant_idx), 32'd0);
        chk("s6_async_err",   32'(o_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) tick();
        chk("s6_late_err", 32'(o_err), 32'd1);
        chk("s6_late_busy", 32'(o_busy), 32'd0);
        chk("s6_late_out", o_req_out, 32'd0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < N; r++) begin
                if (!has_entry(r) && $urandom_range(0, 9) < 3) issue(r, rnd_op(), rnd_op());
            end
            tick();
        end
        drain("rand_drain");
        chk("rand_err", 32'(o_err), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
